// File: rtl/sram_mux_bus_ctrl.sv
// SRAM controller for a multiplexed address/data pad bus with address latches.
// Optional latch address cache: define SRAM_ADDR_CACHE_EN.
module sram_mux_bus_ctrl #(
    parameter int ALE_N = 2,
    parameter int ADRH_W = 4,
    localparam int ADDR_W = 8 * ALE_N + ADRH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    input  logic [3:0]        cfg_wait,
    output logic              rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic [ALE_N-1:0]  sram_ale,
    output logic [ADRH_W-1:0] sram_adrh,
    output logic [7:0]        sram_do,
    input  logic [7:0]        sram_di,
    output logic              sram_bus_oen,
    output logic              sram_rdn,
    output logic              sram_wdn,
    output logic              sram_cen
);

    localparam int IDX_W = (ALE_N > 1) ? $clog2(ALE_N) : 1;

    typedef enum logic [2:0] {
        IDLE, ALE_SET, ALE_HOLD, STROBE, RECOVER
    } state_t;

    state_t            state_q, state_n;
    logic [IDX_W-1:0]  idx_q, idx_n;
    logic [3:0]        cnt_q, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [7:0]        wdata_q;
    logic [3:0]        wait_q;
    logic [ALE_N-1:0]  miss_q, req_miss;

    logic [ALE_N-1:0]  ale_n;
    logic [7:0]        dout_n;
    logic              oen_n, rdn_n, wdn_n, cen_n, rsp_n;

    logic              go_ale, go_str;
    logic [IDX_W:0]    f;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;
    logic [7:0]        sel_wd;
    logic [3:0]        sel_wait;

    // Lowest latch index >= s that still needs an ALE cycle; MSB = found.
    function automatic logic [IDX_W:0] find_miss(
        input logic [ALE_N-1:0] m,
        input int s
    );
        logic [IDX_W:0] r;
        r = '0;
        for (int k = ALE_N - 1; k >= 0; k--) begin
            if (k >= s && m[k]) r = {1'b1, IDX_W'(k)};
        end
        return r;
    endfunction

`ifdef SRAM_ADDR_CACHE_EN
    logic [7:0]       cache_q [ALE_N];
    logic [ALE_N-1:0] cval_q;

    // A latch needs a cycle unless it already holds the requested byte.
    always_comb begin
        req_miss = '1;
        for (int k = 0; k < ALE_N; k++) begin
            if (cval_q[k] && cache_q[k] == req_addr[8*k +: 8])
                req_miss[k] = 1'b0;
        end
    end

    // Track what each external latch holds after every ALE pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cval_q <= '0;
            for (int k = 0; k < ALE_N; k++) cache_q[k] <= 8'h00;
        end else if (state_q == ALE_SET) begin
            cache_q[idx_q] <= addr_q[8*idx_q +: 8];
            cval_q[idx_q]  <= 1'b1;
        end
    end
`else
    assign req_miss = '1;
`endif

    assign req_ready = (state_q == IDLE);

    // Next state plus the pin values to register for the next cycle.
    always_comb begin
        state_n  = state_q;
        idx_n    = idx_q;
        cnt_n    = cnt_q;
        ale_n    = '0;
        dout_n   = sram_do;
        oen_n    = 1'b1;
        rdn_n    = 1'b1;
        wdn_n    = 1'b1;
        cen_n    = 1'b1;
        rsp_n    = 1'b0;
        go_ale   = 1'b0;
        go_str   = 1'b0;
        f        = '0;
        sel_addr = addr_q;
        sel_we   = we_q;
        sel_wd   = wdata_q;
        sel_wait = wait_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    sel_addr = req_addr;
                    sel_we   = req_we;
                    sel_wd   = req_wdata;
                    sel_wait = cfg_wait;
                    f        = find_miss(req_miss, 0);
                    go_ale   = f[IDX_W];
                    go_str   = !f[IDX_W];
                end
            end
            ALE_SET: begin
                state_n = ALE_HOLD;
                oen_n   = 1'b0;
            end
            ALE_HOLD: begin
                f      = find_miss(miss_q, int'(idx_q) + 1);
                go_ale = f[IDX_W];
                go_str = !f[IDX_W];
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_n = RECOVER;
                    rsp_n   = 1'b1;
                end else begin
                    cnt_n = cnt_q - 4'd1;
                    cen_n = 1'b0;
                    rdn_n = we_q;
                    wdn_n = !we_q;
                    oen_n = !we_q;
                end
            end
            RECOVER: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (go_ale) begin
            state_n               = ALE_SET;
            idx_n                 = f[IDX_W-1:0];
            ale_n[f[IDX_W-1:0]]   = 1'b1;
            dout_n                = sel_addr[8*f[IDX_W-1:0] +: 8];
            oen_n                 = 1'b0;
        end
        if (go_str) begin
            state_n = STROBE;
            cnt_n   = sel_wait;
            cen_n   = 1'b0;
            rdn_n   = sel_we;
            wdn_n   = !sel_we;
            oen_n   = !sel_we;
            if (sel_we) dout_n = sel_wd;
        end
    end

    // State, request capture and registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 8'h00;
            wait_q       <= 4'd0;
            miss_q       <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 8'h00;
            sram_ale     <= '0;
            sram_adrh    <= '0;
            sram_do      <= 8'h00;
            sram_bus_oen <= 1'b1;
            sram_rdn     <= 1'b1;
            sram_wdn     <= 1'b1;
            sram_cen     <= 1'b1;
        end else begin
            state_q      <= state_n;
            idx_q        <= idx_n;
            cnt_q        <= cnt_n;
            rsp_valid    <= rsp_n;
            sram_ale     <= ale_n;
            sram_do      <= dout_n;
            sram_bus_oen <= oen_n;
            sram_rdn     <= rdn_n;
            sram_wdn     <= wdn_n;
            sram_cen     <= cen_n;
            if (state_q == IDLE && req_valid) begin
                addr_q    <= req_addr;
                we_q      <= req_we;
                wdata_q   <= req_wdata;
                wait_q    <= cfg_wait;
                miss_q    <= req_miss;
                sram_adrh <= req_addr[ADDR_W-1 -: ADRH_W];
            end
            if (state_q == STROBE && cnt_q == 4'd0 && !we_q)
                rsp_rdata <= sram_di;
        end
    end

endmodule

// File: tb/tb_sram_mux_bus_ctrl.sv
// Scoreboard bench for sram_mux_bus_ctrl (default parameters).
// Expected latencies follow SRAM_ADDR_CACHE_EN when it is defined.
module tb_sram_mux_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  cfg_wait;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic [1:0]  sram_ale;
    logic [3:0]  sram_adrh;
    logic [7:0]  sram_do;
    logic [7:0]  sram_di;
    logic        sram_bus_oen;
    logic        sram_rdn;
    logic        sram_wdn;
    logic        sram_cen;

`ifdef SRAM_ADDR_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    typedef struct {
        bit       rd;
        logic [7:0] rdata;
        int       due;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc;
    int   a1;
    int   n;

    sram_mux_bus_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .cfg_wait(cfg_wait),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_ale(sram_ale), .sram_adrh(sram_adrh),
        .sram_do(sram_do), .sram_di(sram_di),
        .sram_bus_oen(sram_bus_oen), .sram_rdn(sram_rdn),
        .sram_wdn(sram_wdn), .sram_cen(sram_cen)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every rsp_valid.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                m = q.pop_front();
                chk("rsp_time", cyc, m.due);
                if (m.rd) chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, m.rdata});
            end
        end
    end

    task automatic accept(input logic we, input logic [19:0] a,
                          input logic [7:0] wd, input logic [3:0] w,
                          input int lat, input logic [7:0] rd);
        int   k;
        exp_t e;
        req_we    = we;
        req_addr  = a;
        req_wdata = wd;
        cfg_wait  = w;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc     = cyc;
        e.rd    = !we;
        e.rdata = rd;
        e.due   = acc + lat - 1;
        q.push_back(e);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic run_rd(input string nm, input logic [19:0] a,
                          input logic [7:0] di, input logic [3:0] w,
                          input int lat, input int p0, input int p1);
        int c0;
        int c1;
        sram_di = di;
        accept(1'b0, a, 8'h00, w, lat, di);
        req_valid = 1'b0;
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (sram_ale[0]) c0++;
            if (sram_ale[1]) c1++;
        end
        chk({nm, "_ale_pulses"}, {c0[15:0], c1[15:0]},
            {p0[15:0], p1[15:0]});
        drain();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 20'h0;
        req_wdata = 8'h00;
        cfg_wait  = 4'd0;
        sram_di   = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pins",
            {sram_ale, sram_rdn, sram_wdn, sram_cen, sram_bus_oen,
             sram_do, req_ready, rsp_valid, rsp_rdata, sram_adrh},
            {2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0,
             8'h00, 4'h0});

        // Write with default wait.
        accept(1'b1, 20'h5A3C1, 8'h7E, 4'd0, 6, 8'h00);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr_c1", {sram_adrh, sram_ale, sram_do, sram_bus_oen},
            {4'h5, 2'b01, 8'hC1, 1'b0});
        @(negedge clk);
        chk("wr_c2", {sram_ale, sram_do, sram_bus_oen, sram_cen},
            {2'b00, 8'hC1, 1'b0, 1'b1});
        @(negedge clk);
        chk("wr_c3", {sram_ale, sram_do}, {2'b10, 8'hA3});
        repeat (2) @(negedge clk);
        chk("wr_c5", {sram_wdn, sram_cen, sram_rdn, sram_do, sram_bus_oen, sram_ale},
            {1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 2'b00});
        @(negedge clk);
        chk("wr_c6", {sram_wdn, sram_cen, sram_rdn, sram_bus_oen},
            {1'b1, 1'b1, 1'b1, 1'b1});
        drain();

        // Read with three wait states; cfg_wait changes after accept.
        sram_di = 8'h42;
        accept(1'b0, 20'h00010, 8'h00, 4'd3, 9, 8'h42);
        req_valid = 1'b0;
        cfg_wait  = 4'd0;
        @(negedge clk);
        chk("rd_c1", {sram_adrh, sram_ale, sram_do}, {4'h0, 2'b01, 8'h10});
        repeat (3) @(negedge clk);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (!sram_rdn && sram_bus_oen && !sram_cen && sram_wdn) n++;
        end
        chk("rd_strobe_cycles", n, 32'd4);
        @(negedge clk);
        chk("rd_c9", {sram_rdn, sram_cen, sram_bus_oen}, {1'b1, 1'b1, 1'b1});
        drain();

        // Back-to-back writes with req_valid held high.
        accept(1'b1, 20'h12345, 8'h11, 4'd0, 6, 8'h00);
        a1 = acc;
        n  = 0;
        repeat (6) begin
            @(negedge clk);
            if (!req_ready) n++;
        end
        chk("b2b_ready_low", n, 32'd6);
        accept(1'b1, 20'h6789A, 8'h22, 4'd0, 6, 8'h00);
        req_valid = 1'b0;
        chk("b2b_accept_gap", acc - a1, 32'd7);
        drain();
        chk("rdata_hold", {24'd0, rsp_rdata}, 32'h42);

        // Reset during a write strobe aborts the access.
        accept(1'b1, 20'h0BCDE, 8'h55, 4'd2, 8, 8'h00);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_in_strobe", {sram_wdn, sram_cen}, {1'b0, 1'b0});
        #2;
        rst = 1'b1;
        #1;
        chk("abort_async", {sram_wdn, sram_cen, sram_bus_oen, rsp_valid, sram_do},
            {1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        run_rd("after_abort", 20'h0BCDE, 8'h99, 4'd0, 6, 1, 1);

        // Latch reuse between neighbouring addresses.
        run_rd("seq_a", 20'h5A3C1, 8'h3A, 4'd0, 6, 1, 1);
        run_rd("seq_b", 20'h5A3C2, 8'hC5, 4'd0,
               CACHE ? 4 : 6, 1, CACHE ? 0 : 1);
        run_rd("seq_c", 20'h5A3C2, 8'h0F, 4'd0,
               CACHE ? 2 : 6, CACHE ? 0 : 1, CACHE ? 0 : 1);

        // Maximum wait states.
        run_rd("max_wait", 20'h00FF0, 8'hE7, 4'd15, 21, 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
